// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
endpackage

// File: rtl/md_seq.sv
// md_seq: mul/div unit sequencer, busy for exactly N cycles after a start, then one HI/LO write cycle
module md_seq import pipe_ctrl_pkg::*; #(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic is_div,
  output logic md_busy,
  output logic in_run,
  output logic in_done
);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES - 1);
  md_state_t state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt <= '0;
      md_busy <= 1'b0;
    end else if (go && state != MD_RUN) begin
      state <= MD_RUN;
      cnt <= is_div ? DIV_N : MUL_N;
      md_busy <= 1'b1;
    end else if (state == MD_RUN) begin
      if (cnt == '0) begin
        state <= MD_DONE;
        md_busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      state <= MD_IDLE;
    end
  end
  assign in_run = state == MD_RUN;
  assign in_done = state == MD_DONE;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for load-use, HI/LO-busy and taken-branch hazards
module pipeline_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = 6,
  parameter int STALL_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic id_uses_rt,
  input  logic id_md_start,
  input  logic id_is_div,
  input  logic id_reads_hilo,
  input  logic ex_memrd,
  input  logic ex_regwr,
  input  logic [4:0] ex_wr_reg,
  input  logic branch_taken,
  output logic pc_wr_en,
  output logic if_id_wr_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic md_start,
  output logic md_busy,
  output logic [STALL_W-1:0] stall_cycles
);
  logic lu, hl, flush, stall, go, md_ready, in_run, in_done;
  assign lu = ex_memrd & ex_regwr & (ex_wr_reg != REG_ZERO) &
              ((ex_wr_reg == id_rs) | (id_uses_rt & (ex_wr_reg == id_rt)));
  assign hl = in_run & (id_reads_hilo | id_md_start);
  // reset also drains the front of the pipe, so it behaves like a squash
  assign flush = rst | branch_taken;
  assign stall = ~flush & (lu | hl);
  assign md_ready = in_done | ~in_run;
  assign go = id_md_start & ~branch_taken & ~lu & md_ready;
  assign md_start = go & ~rst;
  assign pc_wr_en = ~stall;
  assign if_id_wr_en = ~stall;
  assign if_id_flush = flush;
  assign id_ex_flush = flush | stall;
  md_seq #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md_seq (
    .clk(clk),
    .rst(rst),
    .go(go),
    .is_div(id_is_div),
    .md_busy(md_busy),
    .in_run(in_run),
    .in_done(in_done)
  );
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (stall && ~&stall_cycles) stall_cycles <= stall_cycles + STALL_W'(1);
  end
endmodule
